seg7_multi_disp: RTL and testbench
==================================

Name: seg7_multi_disp

Overview:
Parametrised multi-digit 7-segment display controller for the DE1-SoC HEX displays, with active-low segments. It latches a binary value on a load strobe and renders it on NDIGITS digits, in hex or decimal. Decimal conversion is a sequential double-dabble, one bit per clock. Adds leading-zero blanking, overflow indication (all dashes) and a blink mode; sits between debug/status logic and the HEX pins.

Parameters:
NDIGITS, 6, number of 7-seg digits driven (1..8)
WIDTH, 20, width of input value (1..32)
BLINK_DIV, 25_000_000, clock cycles per blink half-period (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  sample value/mode when high and busy=0
value  in  WIDTH  binary value to display
hex_mode  in  1  1=hexadecimal, 0=decimal (latched with value)
blank_lz  in  1  1=blank leading zero digits (latched with value)
blink_en  in  1  1=blink whole display (live, not latched)
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when display updated
overflow  out  1  last loaded value did not fit in NDIGITS
hex  out  7*NDIGITS  digit k at bits [7k+6:7k], bit order g..a, active-low; digit 0 is least significant

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE; busy=0, done=0, overflow=0.
  - All segment registers 7'b1111111 (blank).
  - Blink counter and phase cleared, phase = on.
  - A reset mid-conversion aborts the conversion; no done pulse is produced.
- FSM states:
  - IDLE: on an edge where load=1, latch value, hex_mode and blank_lz. Go to UPDATE if hex_mode=1, else go to CONV. Internal register busy_r=1 from the next cycle.
  - CONV: WIDTH iterations of shift-and-add-3 on a 4*NDIGITS BCD register, one per clock, then go to UPDATE.
  - UPDATE: one cycle. Segment registers and overflow are written at the end of this cycle; done=1 for the following cycle; return to IDLE.
- busy = (state != IDLE). load while busy=1 is ignored entirely.
- Latency from the load-sampling edge to the segment update edge:
  - hex mode: 2 edges.
  - decimal mode: WIDTH+2 edges. done is high in the cycle after the update edge.
- Overflow:
  - decimal: latched value > 10^NDIGITS-1.
  - hex: value >> (4*NDIGITS) != 0 (constant 0 if WIDTH <= 4*NDIGITS).
  - On overflow, every digit shows dash 7'b0111111; blanking is not applied.
- Digit encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - BCD nibble >9 cannot occur; encode it as blank.
- Leading-zero blank (blank_lz=1): digits above the most significant nonzero digit show 1111111. Digit 0 is always shown, so value 0 displays "0".
- Blink:
  - Free-running counter 0..BLINK_DIV-1; phase toggles on wrap.
  - While blink_en=1 and phase=off, the hex output is all 1111111.
  - blink_en=0 forces output on immediately (combinational masking of the registered segments); the counter keeps running.
- Segment registers hold their value between loads.

Decomposition:
- Package seg7_pkg:
  - SEG_* localparams for 0-F, SEG_BLANK, SEG_DASH.
  - State enum {IDLE, CONV, UPDATE}.
  - Function nibble_to_seg(logic [3:0] n) returning the 7-bit pattern.
- Sub-module bin2bcd_seq (params WIDTH, NDIGITS):
  - Ports: start, bin, bcd out, valid.
  - Sequential double-dabble; seg7_multi_disp instantiates it and drives CONV off its valid.

Test Plan:
Configuration for all scenarios: NDIGITS=6, WIDTH=20, BLINK_DIV=4.
1. Decimal: load value=123456, hex_mode=0, blank_lz=0. Required: busy=1 for 21 cycles; done pulses once; hex[41:0] digits 5..0 = 1,2,3,4,5,6 (1111001,0100100,0110000,0011001,0010010,0000010); overflow=0.
2. Hex with blanking: load value=20'h0ABCD, hex_mode=1, blank_lz=1. Required: update 2 edges after load; digits 5,4 = 1111111; digits 3..0 = A,b,C,d; done one cycle.
3. Decimal overflow: load value=1000000, hex_mode=0. Required: overflow=1; all six digits 0111111. A following load of value=0 with blank_lz=1 gives overflow=0, digits 5..1 blank, digit 0 = 1000000.
4. Load while busy: load 42 (decimal), then assert load with value=999 at cycle 5. Required: second load ignored; final display 42 (digits 1,0 = 0011001,0100100 with blank_lz=1); exactly one done.
5. Reset mid-conversion: load 777777, pull rst_n low at cycle 10 for 1 cycle. Required: hex all 1111111, busy=0, no done. A subsequent load of 5 displays "5" correctly.
6. Blink: display 8 in hex, blink_en=1. Required: digit 0 alternates 0000000 / 1111111 every 4 cycles. Dropping blink_en restores 0000000 the same cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit 7-segment display controller:
// active-low segment patterns (bit order g..a), FSM states and the nibble encoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'ha: s = SEG_A;
            4'hb: s = SEG_B;
            4'hc: s = SEG_C;
            4'hd: s = SEG_D;
            4'he: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_multi_disp_bin2bcd.sv
// Sequential double-dabble: one shift-and-add-3 step per clock, WIDTH steps per conversion.
// valid is high during the final step, so bcd holds the finished result after that edge.
module bin2bcd_seq #(
    parameter int WIDTH   = 20,
    parameter int NDIGITS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       bin,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic                   valid
);

    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    sh_r;
    logic [BW-1:0]       bcd_r;
    logic [CW-1:0]       cnt_r;
    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;

    always_comb begin
        adj = bcd_r;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, sh_r} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r  <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
        end else if (start) begin
            sh_r  <= bin;
            bcd_r <= '0;
            cnt_r <= CW'(WIDTH);
        end else if (cnt_r != '0) begin
            bcd_r <= shifted[BW+WIDTH-1:WIDTH];
            sh_r  <= shifted[WIDTH-1:0];
            cnt_r <= cnt_r - 1'b1;
        end
    end

    assign bcd   = bcd_r;
    assign valid = (cnt_r == CW'(1));

endmodule

// File: rtl/seg7_multi_disp.sv
// Multi-digit 7-segment controller: latches a value on load, renders it in hex or
// decimal with leading-zero blanking, overflow dashes and a free-running blink mask.
import seg7_pkg::*;

module seg7_multi_disp #(
    parameter int NDIGITS   = 6,
    parameter int WIDTH     = 20,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH-1:0]       value,
    input  logic                   hex_mode,
    input  logic                   blank_lz,
    input  logic                   blink_en,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [7*NDIGITS-1:0]   hex
);

    localparam int          BW      = 4 * NDIGITS;
    localparam int          DW      = 7 * NDIGITS;
    localparam int          BCW     = $clog2(BLINK_DIV);
    localparam logic [63:0] DEC_MAX = (64'd10 ** NDIGITS) - 64'd1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] value_r;
    logic             hex_mode_r, blank_lz_r;
    logic [DW-1:0]    seg_r, seg_nx;
    logic             ovf_r, ovf_nx;
    logic             done_r;
    logic [BCW-1:0]   blink_cnt;
    logic             phase_off;

    logic             conv_start;
    logic [BW-1:0]    bcd;
    logic             bcd_valid;
    logic [63:0]      v64;
    logic [3:0]       nib;
    logic             seen;

    // The converter samples the live input on the same edge the value is latched.
    assign conv_start = (state == IDLE) && load && !hex_mode;

    bin2bcd_seq #(
        .WIDTH   (WIDTH),
        .NDIGITS (NDIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value),
        .bcd   (bcd),
        .valid (bcd_valid)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = hex_mode ? UPDATE : CONV;
            CONV:    if (bcd_valid) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Digits are scanned from the top so 'seen' marks the first nonzero digit.
    always_comb begin
        v64    = 64'(value_r);
        ovf_nx = hex_mode_r ? ((v64 >> BW) != 64'd0) : (v64 > DEC_MAX);
        seg_nx = '1;
        seen   = 1'b0;
        nib    = 4'h0;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            nib  = hex_mode_r ? v64[4*k +: 4] : bcd[4*k +: 4];
            seen = seen | (nib != 4'h0);
            if (ovf_nx) begin
                seg_nx[7*k +: 7] = SEG_DASH;
            end else if (blank_lz_r && !seen && (k != 0)) begin
                seg_nx[7*k +: 7] = SEG_BLANK;
            end else if (!hex_mode_r && (nib > 4'd9)) begin
                seg_nx[7*k +: 7] = SEG_BLANK;
            end else begin
                seg_nx[7*k +: 7] = nibble_to_seg(nib);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            value_r    <= '0;
            hex_mode_r <= 1'b0;
            blank_lz_r <= 1'b0;
            seg_r      <= '1;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= (state == UPDATE);
            if (state == IDLE && load) begin
                value_r    <= value;
                hex_mode_r <= hex_mode;
                blank_lz_r <= blank_lz;
            end
            if (state == UPDATE) begin
                seg_r <= seg_nx;
                ovf_r <= ovf_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_off <= 1'b0;
        end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase_off <= ~phase_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_r;
    assign overflow = ovf_r;
    assign hex      = (blink_en && phase_off) ? {DW{1'b1}} : seg_r;

endmodule

// File: tb/tb_seg7_multi_disp.sv
// Directed bench for seg7_multi_disp with NDIGITS=6, WIDTH=20, BLINK_DIV=4.
module tb_seg7_multi_disp;

    localparam int NDIGITS   = 6;
    localparam int WIDTH     = 20;
    localparam int BLINK_DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000, SB_ = 7'b0000011, SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001, BL = 7'b1111111, DS = 7'b0111111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             hex_mode = 1'b0;
    logic             blank_lz = 1'b0;
    logic             blink_en = 1'b0;
    logic             busy, done, overflow;
    logic [41:0]      hex;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    seg7_multi_disp #(
        .NDIGITS   (NDIGITS),
        .WIDTH     (WIDTH),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input logic hm, input logic bl);
        load = 1'b1;
        value = v;
        hex_mode = hm;
        blank_lz = bl;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        int d0;
        logic [6:0] first, cur, other;

        // reset
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_hex", 64'(hex), 64'(42'h3ffffffffff));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: decimal 123456
        d0 = done_cnt;
        do_load(20'd123456, 1'b0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("dec_busy_cycles", 64'(n), 64'd21);
        check("dec_done", 64'(done), 64'd1);
        check("dec_hex", 64'(hex), 64'({S1, S2, S3, S4, S5, S6}));
        check("dec_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        check("dec_done_low", 64'(done), 64'd0);
        check("dec_done_count", 64'(done_cnt - d0), 64'd1);

        // 2: hex with blanking, update two edges after load
        d0 = done_cnt;
        do_load(20'h0abcd, 1'b1, 1'b1);
        check("hex_busy", 64'(busy), 64'd1);
        check("hex_hold", 64'(hex), 64'({S1, S2, S3, S4, S5, S6}));
        @(negedge clk);
        check("hex_done", 64'(done), 64'd1);
        check("hex_hex", 64'(hex), 64'({BL, BL, SA, SB_, SC, SD}));
        check("hex_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        check("hex_done_count", 64'(done_cnt - d0), 64'd1);

        // 3: decimal overflow, then zero with blanking
        do_load(20'd1000000, 1'b0, 1'b0);
        wait_done("ovf_wait");
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_hex", 64'(hex), 64'({DS, DS, DS, DS, DS, DS}));
        @(negedge clk);
        do_load(20'd0, 1'b0, 1'b1);
        wait_done("zero_wait");
        check("zero_ovf", 64'(overflow), 64'd0);
        check("zero_hex", 64'(hex), 64'({BL, BL, BL, BL, BL, S0}));
        @(negedge clk);

        // 4: load while busy is ignored
        d0 = done_cnt;
        do_load(20'd42, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        load = 1'b1;
        value = 20'd999;
        @(negedge clk);
        load = 1'b0;
        wait_done("lwb_wait");
        check("lwb_hex", 64'(hex), 64'({BL, BL, BL, BL, S4, S2}));
        repeat (30) @(negedge clk);
        check("lwb_done_count", 64'(done_cnt - d0), 64'd1);
        check("lwb_busy", 64'(busy), 64'd0);
        check("lwb_hex_hold", 64'(hex), 64'({BL, BL, BL, BL, S4, S2}));

        // 5: reset mid-conversion
        d0 = done_cnt;
        do_load(20'd777777, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hex", 64'(hex), 64'(42'h3ffffffffff));
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("mid_rst_hex_after", 64'(hex), 64'(42'h3ffffffffff));
        check("mid_rst_busy_after", 64'(busy), 64'd0);
        do_load(20'd5, 1'b0, 1'b1);
        wait_done("five_wait");
        check("five_hex", 64'(hex), 64'({BL, BL, BL, BL, BL, S5}));
        @(negedge clk);

        // 6: blink
        do_load(20'h8, 1'b1, 1'b1);
        wait_done("blink_load_wait");
        check("blink_base", 64'(hex), 64'({BL, BL, BL, BL, BL, S8}));
        blink_en = 1'b1;
        @(negedge clk);
        first = hex[6:0];
        n = 0;
        while (hex[6:0] === first && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("blink_edge_seen", 64'(hex[6:0] !== first), 64'd1);
        cur = hex[6:0];
        other = (cur == S8) ? BL : S8;
        check("blink_level", 64'((cur == S8) || (cur == BL)), 64'd1);
        for (int i = 0; i < 12; i++) begin
            check("blink_seq", 64'(hex[6:0]), 64'((((i / 4) % 2) == 0) ? cur : other));
            @(negedge clk);
        end
        n = 0;
        while (hex[6:0] !== BL && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("blink_off_phase", 64'(hex), 64'(42'h3ffffffffff));
        blink_en = 1'b0;
        #1;
        check("blink_release", 64'(hex), 64'({BL, BL, BL, BL, BL, S8}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
